kbd_char_decoder: RTL and testbench

- Sits between the PS/2 byte receiver and the text-terminal display stage.
- Pops scan-code bytes from the receiver FIFO and tracks make/break/extended prefixes, Shift and CapsLock.
- Translates key presses into the display's press_flag / special_char / char_ascii interface.
- Stretches each press so the display's slow refresh clock samples it exactly once.

---
 rtl/kbd_pkg.sv | 28 ++
 rtl/kbd_char_decoder_scan2ascii.sv | 60 ++++++
 rtl/kbd_char_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_kbd_char_decoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard character decoder: special-key codes,
// PS/2 set-2 scan codes and the prefix FSM state encoding.
package kbd_pkg;

  localparam logic [3:0] SPC_NONE  = 4'd0;
  localparam logic [3:0] SPC_LEFT  = 4'd1;
  localparam logic [3:0] SPC_RIGHT = 4'd4;
  localparam logic [3:0] SPC_ENTER = 4'd5;
  localparam logic [3:0] SPC_BKSP  = 4'd6;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

endpackage

// File: rtl/kbd_char_decoder_scan2ascii.sv
// Combinational scan-code to ASCII ROM. Letters follow shift XOR caps;
// digits and punctuation follow shift only. A result of 0 means unmapped.
module scan2ascii
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift_down,
  input  logic       caps,
  output logic [7:0] ascii
);

  // Each entry packs {unshifted, shifted}; letters store lower case first.
  function automatic logic [15:0] rom_entry(input logic [7:0] sc);
    logic [15:0] e;
    case (sc)
      8'h1C: e = {8'h61, 8'h41};  8'h32: e = {8'h62, 8'h42};
      8'h21: e = {8'h63, 8'h43};  8'h23: e = {8'h64, 8'h44};
      8'h24: e = {8'h65, 8'h45};  8'h2B: e = {8'h66, 8'h46};
      8'h34: e = {8'h67, 8'h47};  8'h33: e = {8'h68, 8'h48};
      8'h43: e = {8'h69, 8'h49};  8'h3B: e = {8'h6A, 8'h4A};
      8'h42: e = {8'h6B, 8'h4B};  8'h4B: e = {8'h6C, 8'h4C};
      8'h3A: e = {8'h6D, 8'h4D};  8'h31: e = {8'h6E, 8'h4E};
      8'h44: e = {8'h6F, 8'h4F};  8'h4D: e = {8'h70, 8'h50};
      8'h15: e = {8'h71, 8'h51};  8'h2D: e = {8'h72, 8'h52};
      8'h1B: e = {8'h73, 8'h53};  8'h2C: e = {8'h74, 8'h54};
      8'h3C: e = {8'h75, 8'h55};  8'h2A: e = {8'h76, 8'h56};
      8'h1D: e = {8'h77, 8'h57};  8'h22: e = {8'h78, 8'h58};
      8'h35: e = {8'h79, 8'h59};  8'h1A: e = {8'h7A, 8'h5A};
      8'h45: e = {8'h30, 8'h29};  8'h16: e = {8'h31, 8'h21};
      8'h1E: e = {8'h32, 8'h40};  8'h26: e = {8'h33, 8'h23};
      8'h25: e = {8'h34, 8'h24};  8'h2E: e = {8'h35, 8'h25};
      8'h36: e = {8'h36, 8'h5E};  8'h3D: e = {8'h37, 8'h26};
      8'h3E: e = {8'h38, 8'h2A};  8'h46: e = {8'h39, 8'h28};
      8'h0E: e = {8'h60, 8'h7E};  8'h4E: e = {8'h2D, 8'h5F};
      8'h55: e = {8'h3D, 8'h2B};  8'h54: e = {8'h5B, 8'h7B};
      8'h5B: e = {8'h5D, 8'h7D};  8'h5D: e = {8'h5C, 8'h7C};
      8'h4C: e = {8'h3B, 8'h3A};  8'h52: e = {8'h27, 8'h22};
      8'h41: e = {8'h2C, 8'h3C};  8'h49: e = {8'h2E, 8'h3E};
      8'h4A: e = {8'h2F, 8'h3F};  8'h29: e = {8'h20, 8'h20};
      default: e = {8'h00, 8'h00};
    endcase
    return e;
  endfunction

  logic [15:0] entry_s;
  logic        is_letter_s;

  assign entry_s     = rom_entry(code);
  assign is_letter_s = (entry_s[15:8] >= 8'h61) && (entry_s[15:8] <= 8'h7A);

  always_comb begin
    ascii = 8'h00;
    if (is_letter_s) begin
      ascii = (shift_down ^ caps) ? entry_s[7:0] : entry_s[15:8];
    end else begin
      ascii = shift_down ? entry_s[7:0] : entry_s[15:8];
    end
  end

endmodule

// File: rtl/kbd_char_decoder.sv
// Pops PS/2 scan codes, tracks prefixes and modifiers, and presents each
// accepted key press to the display as a press_flag pulse of PRESS_HOLD cycles.
module kbd_char_decoder
  import kbd_pkg::*;
#(
  parameter int PRESS_HOLD = 9_000_002
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  output logic       nextdata_n,
  output logic       press_flag,
  output logic [3:0] special_char,
  output logic [7:0] char_ascii,
  output logic       caps_led
);

  localparam int               CNT_W     = $clog2(PRESS_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(PRESS_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  kbd_state_e       state_r, state_nxt_s;
  logic             nextdata_n_r;
  logic             press_flag_r;
  logic [3:0]       special_r;
  logic [7:0]       ascii_r;
  logic             caps_r;
  logic             shift_r;
  logic             caps_down_r;
  logic [CNT_W-1:0] hold_cnt_r;

  logic             pop_s;
  logic             make_s;
  logic             break_s;
  logic             ext_key_s;
  logic [7:0]       rom_ascii_s;
  logic             mapped_s;
  logic [7:0]       map_ascii_s;
  logic [3:0]       map_special_s;
  logic             accept_s;

  // A byte is consumed only when the previous pop strobe has already ended.
  assign pop_s    = ps2_ready & nextdata_n_r;
  assign accept_s = make_s & mapped_s & ~press_flag_r;

  scan2ascii u_rom (
    .code       (ps2_data),
    .shift_down (shift_r),
    .caps       (caps_r),
    .ascii      (rom_ascii_s)
  );

  // Prefix state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Prefix next state; prefixes seen after a break prefix are ordinary codes.
  always_comb begin
    state_nxt_s = state_r;
    if (pop_s) begin
      case (state_r)
        ST_IDLE: begin
          if (ps2_data == SC_EXT) begin
            state_nxt_s = ST_EXT;
          end else if (ps2_data == SC_BRK) begin
            state_nxt_s = ST_BRK;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_EXT:     state_nxt_s = (ps2_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK:     state_nxt_s = ST_IDLE;
        ST_EXT_BRK: state_nxt_s = ST_IDLE;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Classify the consumed byte as a make or break of a normal/extended key.
  always_comb begin
    make_s    = 1'b0;
    break_s   = 1'b0;
    ext_key_s = 1'b0;
    if (pop_s) begin
      case (state_r)
        ST_IDLE: make_s = (ps2_data != SC_EXT) && (ps2_data != SC_BRK);
        ST_EXT: begin
          make_s    = (ps2_data != SC_BRK);
          ext_key_s = 1'b1;
        end
        ST_BRK: break_s = 1'b1;
        ST_EXT_BRK: begin
          break_s   = 1'b1;
          ext_key_s = 1'b1;
        end
        default: begin
          make_s    = 1'b0;
          break_s   = 1'b0;
          ext_key_s = 1'b0;
        end
      endcase
    end else begin
      make_s    = 1'b0;
      break_s   = 1'b0;
      ext_key_s = 1'b0;
    end
  end

  // Key mapping: arrows come only from extended codes, the rest from the ROM.
  always_comb begin
    mapped_s      = 1'b0;
    map_ascii_s   = 8'h00;
    map_special_s = SPC_NONE;
    if (ext_key_s) begin
      case (ps2_data)
        SC_LEFT: begin
          mapped_s      = 1'b1;
          map_special_s = SPC_LEFT;
        end
        SC_RIGHT: begin
          mapped_s      = 1'b1;
          map_special_s = SPC_RIGHT;
        end
        default: mapped_s = 1'b0;
      endcase
    end else begin
      case (ps2_data)
        SC_ENTER: begin
          mapped_s      = 1'b1;
          map_special_s = SPC_ENTER;
        end
        SC_BKSP: begin
          mapped_s      = 1'b1;
          map_special_s = SPC_BKSP;
        end
        default: begin
          mapped_s    = (rom_ascii_s != 8'h00);
          map_ascii_s = rom_ascii_s;
        end
      endcase
    end
  end

  // Pop strobe: one low cycle per consumed byte.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      nextdata_n_r <= 1'b1;
    end else begin
      nextdata_n_r <= ~pop_s;
    end
  end

  // Modifiers; caps_down_r blocks typematic repeats from re-toggling CapsLock.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shift_r     <= 1'b0;
      caps_r      <= 1'b0;
      caps_down_r <= 1'b0;
    end else if (make_s && !ext_key_s) begin
      if ((ps2_data == SC_LSHIFT) || (ps2_data == SC_RSHIFT)) begin
        shift_r <= 1'b1;
      end
      if ((ps2_data == SC_CAPS) && !caps_down_r) begin
        caps_r      <= ~caps_r;
        caps_down_r <= 1'b1;
      end
    end else if (break_s && !ext_key_s) begin
      if ((ps2_data == SC_LSHIFT) || (ps2_data == SC_RSHIFT)) begin
        shift_r <= 1'b0;
      end
      if (ps2_data == SC_CAPS) begin
        caps_down_r <= 1'b0;
      end
    end
  end

  // Hold timer: flag stays up until the edge after the counter has run out.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hold_cnt_r   <= CNT_ZERO;
      press_flag_r <= 1'b0;
    end else if (accept_s) begin
      hold_cnt_r   <= HOLD_LOAD;
      press_flag_r <= 1'b1;
    end else begin
      if (hold_cnt_r != CNT_ZERO) begin
        hold_cnt_r <= hold_cnt_r - CNT_ONE;
      end
      press_flag_r <= (hold_cnt_r != CNT_ZERO);
    end
  end

  // Character registers keep the last accepted key.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ascii_r   <= 8'h00;
      special_r <= SPC_NONE;
    end else if (accept_s) begin
      ascii_r   <= map_ascii_s;
      special_r <= map_special_s;
    end
  end

  assign nextdata_n   = nextdata_n_r;
  assign press_flag   = press_flag_r;
  assign special_char = special_r;
  assign char_ascii   = ascii_r;
  assign caps_led     = caps_r;

endmodule

// File: tb/tb_kbd_char_decoder.sv
// Self-checking bench for kbd_char_decoder: a per-byte directed table, a few
// hand-written multi-cycle sequences and random traffic against a key model.
module tb_kbd_char_decoder;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       nextdata_n;
  logic       press_flag;
  logic [3:0] special_char;
  logic [7:0] char_ascii;
  logic       caps_led;

  kbd_char_decoder #(.PRESS_HOLD(H)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .ps2_data     (ps2_data),
    .ps2_ready    (ps2_ready),
    .nextdata_n   (nextdata_n),
    .press_flag   (press_flag),
    .special_char (special_char),
    .char_ascii   (char_ascii),
    .caps_led     (caps_led)
  );

  always #5 clk = ~clk;

  // Reference key tables (set-2 scan codes in character order).
  localparam logic [7:0] LET_SC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15,
    8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG_SC [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] PUN_SC [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D,
    8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  localparam logic [7:0] DIG_SH [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25,
    8'h5E, 8'h26, 8'h2A, 8'h28};
  localparam logic [7:0] PUN_LO [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C,
    8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  localparam logic [7:0] PUN_SH [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C,
    8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic sh, input logic cp);
    for (int i = 0; i < 26; i++)
      if (c == LET_SC[i]) return (sh ^ cp) ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (c == DIG_SC[i]) return sh ? DIG_SH[i] : 8'(8'h30 + i);
    for (int i = 0; i < 11; i++)
      if (c == PUN_SC[i]) return sh ? PUN_SH[i] : PUN_LO[i];
    if (c == 8'h29) return 8'h20;
    return 8'h00;
  endfunction

  // Behavioural model state.
  logic       m_ndn, m_flag, m_caps, m_shift, m_capsdn, m_ext, m_brk;
  logic [7:0] m_ascii;
  logic [3:0] m_spc;
  int         m_rem;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_ndn <= 1'b1; m_flag <= 1'b0; m_caps <= 1'b0; m_shift <= 1'b0;
      m_capsdn <= 1'b0; m_ext <= 1'b0; m_brk <= 1'b0;
      m_ascii <= 8'h00; m_spc <= 4'd0; m_rem <= 0;
    end else begin : step
      logic pop, make, brk, ext, mapped, n_ext, n_brk, n_shift, n_caps, n_capsdn, n_flag;
      logic [7:0] b, asc, n_ascii;
      logic [3:0] spc, n_spc;
      int n_rem;
      b = ps2_data;
      pop = ps2_ready && m_ndn;
      n_rem = (m_rem > 0) ? m_rem - 1 : 0;
      n_flag = (n_rem > 0);
      n_ext = m_ext; n_brk = m_brk; n_shift = m_shift; n_caps = m_caps; n_capsdn = m_capsdn;
      n_ascii = m_ascii; n_spc = m_spc;
      make = 1'b0; brk = 1'b0; ext = 1'b0;
      if (pop) begin
        if (m_brk) begin brk = 1'b1; ext = m_ext; n_brk = 1'b0; n_ext = 1'b0; end
        else if (m_ext) begin
          if (b == 8'hF0) n_brk = 1'b1;
          else begin make = 1'b1; ext = 1'b1; n_ext = 1'b0; end
        end
        else if (b == 8'hE0) n_ext = 1'b1;
        else if (b == 8'hF0) n_brk = 1'b1;
        else make = 1'b1;
      end
      if (!ext && make) begin
        if (b == 8'h12 || b == 8'h59) n_shift = 1'b1;
        if (b == 8'h58 && !m_capsdn) begin n_caps = ~m_caps; n_capsdn = 1'b1; end
      end
      if (!ext && brk) begin
        if (b == 8'h12 || b == 8'h59) n_shift = 1'b0;
        if (b == 8'h58) n_capsdn = 1'b0;
      end
      asc = 8'h00; spc = 4'd0;
      if (ext) begin
        if (b == 8'h6B) spc = 4'd1;
        else if (b == 8'h74) spc = 4'd4;
        mapped = (spc != 4'd0);
      end else begin
        if (b == 8'h5A) spc = 4'd5;
        else if (b == 8'h66) spc = 4'd6;
        else asc = ref_ascii(b, m_shift, m_caps);
        mapped = (spc != 4'd0) || (asc != 8'h00);
      end
      if (make && mapped && !m_flag) begin
        n_rem = H; n_flag = 1'b1; n_ascii = asc; n_spc = spc;
      end
      m_ndn <= !pop; m_flag <= n_flag; m_rem <= n_rem;
      m_ext <= n_ext; m_brk <= n_brk; m_shift <= n_shift; m_caps <= n_caps;
      m_capsdn <= n_capsdn; m_ascii <= n_ascii; m_spc <= n_spc;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int rises = 0;
  int hi_len = 0;
  logic flag_prev = 1'b0;
  int widths[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: compare all outputs with the model, track press pulses.
  task automatic tick();
    @(negedge clk);
    vectors++;
    if ({nextdata_n, press_flag, special_char, char_ascii, caps_led} !==
        {m_ndn, m_flag, m_spc, m_ascii, m_caps}) begin
      miscompares++;
      $display("FAIL cycle@%0t: ndn/flag/spc/ascii/caps got %b/%b/%0d/%h/%b expected %b/%b/%0d/%h/%b",
               $time, nextdata_n, press_flag, special_char, char_ascii, caps_led,
               m_ndn, m_flag, m_spc, m_ascii, m_caps);
    end
    if (press_flag && !flag_prev) rises++;
    if (press_flag) hi_len++;
    else if (flag_prev) begin widths.push_back(hi_len); hi_len = 0; end
    else hi_len = 0;
    flag_prev = press_flag;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ps2_data = b;
    ps2_ready = 1'b1;
    do begin tick(); n++; end while (nextdata_n !== 1'b0 && n < 8);
    ps2_ready = 1'b0;
    chk("pop_strobe", int'(nextdata_n), 0);
  endtask

  typedef struct {
    logic [7:0] b;
    int         rise;
    logic [7:0] asc;
    logic [3:0] spc;
    logic       caps;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [7:0] b, input int r, input logic [7:0] a,
                              input logic [3:0] s, input logic c);
    vec_t v;
    v.b = b; v.rise = r; v.asc = a; v.spc = s; v.caps = c;
    tbl.push_back(v);
  endfunction

  localparam logic [7:0] POOL [19] = '{8'h1C, 8'h32, 8'h45, 8'h16, 8'h4E, 8'h29,
    8'h12, 8'h59, 8'h58, 8'hF0, 8'hE0, 8'h5A, 8'h66, 8'h6B, 8'h74, 8'h07, 8'h0D,
    8'h52, 8'h4A};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, pops;
    add(8'h1C,1,8'h61,4'd0,1'b0); add(8'hF0,0,8'h61,4'd0,1'b0); add(8'h1C,0,8'h61,4'd0,1'b0);
    add(8'h12,0,8'h61,4'd0,1'b0); add(8'h1C,1,8'h41,4'd0,1'b0); add(8'hF0,0,8'h41,4'd0,1'b0);
    add(8'h1C,0,8'h41,4'd0,1'b0); add(8'hF0,0,8'h41,4'd0,1'b0); add(8'h12,0,8'h41,4'd0,1'b0);
    add(8'h58,0,8'h41,4'd0,1'b1); add(8'hF0,0,8'h41,4'd0,1'b1); add(8'h58,0,8'h41,4'd0,1'b1);
    add(8'h1C,1,8'h41,4'd0,1'b1); add(8'h12,0,8'h41,4'd0,1'b1); add(8'h1C,1,8'h61,4'd0,1'b1);
    add(8'hF0,0,8'h61,4'd0,1'b1); add(8'h1C,0,8'h61,4'd0,1'b1); add(8'hF0,0,8'h61,4'd0,1'b1);
    add(8'h12,0,8'h61,4'd0,1'b1); add(8'hE0,0,8'h61,4'd0,1'b1); add(8'h6B,1,8'h00,4'd1,1'b1);
    add(8'hE0,0,8'h00,4'd1,1'b1); add(8'hF0,0,8'h00,4'd1,1'b1); add(8'h6B,0,8'h00,4'd1,1'b1);
    add(8'hE0,0,8'h00,4'd1,1'b1); add(8'h74,1,8'h00,4'd4,1'b1); add(8'h5A,1,8'h00,4'd5,1'b1);
    add(8'h66,1,8'h00,4'd6,1'b1); add(8'h07,0,8'h00,4'd6,1'b1); add(8'h0D,0,8'h00,4'd6,1'b1);
    add(8'h58,0,8'h00,4'd6,1'b0); add(8'hF0,0,8'h00,4'd6,1'b0); add(8'h58,0,8'h00,4'd6,1'b0);
    add(8'h58,0,8'h00,4'd6,1'b1); add(8'h58,0,8'h00,4'd6,1'b1); add(8'hF0,0,8'h00,4'd6,1'b1);
    add(8'h58,0,8'h00,4'd6,1'b1); add(8'h29,1,8'h20,4'd0,1'b1); add(8'hF0,0,8'h20,4'd0,1'b1);
    add(8'h29,0,8'h20,4'd0,1'b1); add(8'hF0,0,8'h20,4'd0,1'b1); add(8'hF0,0,8'h20,4'd0,1'b1);
    add(8'h1C,1,8'h41,4'd0,1'b1); add(8'h12,0,8'h41,4'd0,1'b1); add(8'h16,1,8'h21,4'd0,1'b1);
    add(8'hF0,0,8'h21,4'd0,1'b1); add(8'h12,0,8'h21,4'd0,1'b1); add(8'h16,1,8'h31,4'd0,1'b1);

    // Reset state.
    repeat (3) tick();
    chk("rst_press_flag", int'(press_flag), 0);
    chk("rst_nextdata_n", int'(nextdata_n), 1);
    chk("rst_special", int'(special_char), 0);
    chk("rst_ascii", int'(char_ascii), 0);
    chk("rst_caps", int'(caps_led), 0);
    clrn = 1'b1;
    repeat (2) tick();

    // Directed per-byte table; each byte is given time for the hold to expire.
    foreach (tbl[i]) begin
      r0 = rises;
      send_byte(tbl[i].b);
      repeat (11) tick();
      chk($sformatf("tbl%0d_rise", i), rises - r0, tbl[i].rise);
      chk($sformatf("tbl%0d_ascii", i), int'(char_ascii), int'(tbl[i].asc));
      chk($sformatf("tbl%0d_special", i), int'(special_char), int'(tbl[i].spc));
      chk($sformatf("tbl%0d_caps", i), int'(caps_led), int'(tbl[i].caps));
    end

    // Continuous ready with ten 0x1C makes: two pulses of exactly H cycles.
    widths.delete();
    r0 = rises;
    pops = 0;
    ps2_data = 8'h1C;
    ps2_ready = 1'b1;
    for (int n = 0; n < 60 && pops < 10; n++) begin
      tick();
      if (nextdata_n == 1'b0) pops++;
    end
    ps2_ready = 1'b0;
    repeat (12) tick();
    chk("burst_pops", pops, 10);
    chk("burst_pulses", rises - r0, 2);
    chk("burst_width_count", widths.size(), 2);
    foreach (widths[i]) chk($sformatf("burst_width%0d", i), widths[i], H);

    // Reset mid-hold after an extended prefix was consumed.
    send_byte(8'h1C);
    send_byte(8'hE0);
    chk("midhold_flag", int'(press_flag), 1);
    #2 clrn = 1'b0;
    #1;
    chk("async_rst_flag", int'(press_flag), 0);
    chk("async_rst_ndn", int'(nextdata_n), 1);
    chk("async_rst_ascii", int'(char_ascii), 0);
    chk("async_rst_caps", int'(caps_led), 0);
    repeat (2) tick();
    clrn = 1'b1;
    tick();
    r0 = rises;
    send_byte(8'h6B);
    repeat (11) tick();
    chk("post_rst_6B_rise", rises - r0, 0);
    chk("post_rst_6B_special", int'(special_char), 0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      tick();
      ps2_ready = 1'($urandom_range(0, 1));
      ps2_data = POOL[$urandom_range(0, 18)];
    end
    ps2_ready = 1'b0;
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
